// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, imem request issue and prefetch FIFO.
// Hands {pc, inst} to decode over a valid/ready handshake.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] inst_pc4
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW:0] CAP = DEPTH[PW:0];

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] inst;
    } entry_t;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [PW-1:0]     wptr;
    logic [PW-1:0]     rptr;
    logic [PW-1:0]     count;
    logic [PW:0]       credit;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] req_pc;
    logic              inflight;
    logic              kill;
    logic              accept;
    logic              push;
    logic              pop;
    logic              unused_lsb;

    assign unused_lsb = ^redirect_pc[1:0];

    assign count  = wptr - rptr;
    assign credit = {1'b0, count} + {{PW{1'b0}}, inflight};

    // A pop in the same cycle does not free credit; keeps the path short.
    assign imem_req  = reset && !redirect && (credit < CAP);
    assign imem_addr = pc;
    assign accept    = imem_req && imem_gnt;
    assign push      = inflight && !kill;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;

    assign head     = mem[rptr[AW-1:0]];
    assign inst     = inst_valid ? head.inst : '0;
    assign inst_pc  = inst_valid ? head.pc : '0;
    assign inst_pc4 = inst_pc + ADDR_W'(4);

    // PC, in-flight tracking and FIFO pointers; redirect flushes everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc       <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            kill     <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
        end else begin
            inflight <= accept;
            kill     <= redirect ? accept : 1'b0;
            if (accept) begin
                req_pc <= pc;
            end
            if (redirect) begin
                pc   <= {redirect_pc[ADDR_W-1:2], 2'b00};
                wptr <= '0;
                rptr <= '0;
            end else begin
                if (accept) begin
                    pc <= pc + ADDR_W'(4);
                end
                if (push) begin
                    wptr <= wptr + PW'(1);
                end
                if (pop) begin
                    rptr <= rptr + PW'(1);
                end
            end
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (reset && !redirect && push) begin
            mem[wptr[AW-1:0]] <= '{pc: req_pc, inst: imem_rdata};
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table, directed corner cases and a randomized
// run checked against an in-order fetch stream model.
module tb_fetch_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] K     = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_pc4   (inst_pc4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory: data for an accepted address arrives the following cycle,
    // junk otherwise so that any stray push is visible.
    logic [31:0] mem_nxt;
    always @(negedge clk) begin
        mem_nxt = (imem_req && imem_gnt) ? (imem_addr ^ K) : $urandom;
    end
    always @(posedge clk) begin
        #1;
        imem_rdata = mem_nxt;
    end

    // Stream model: consumer must see consecutive PCs from the last
    // restart point, requests must go out in order, and
    // accepted-but-unconsumed work must never exceed DEPTH.
    logic [31:0] exp_pc;
    logic [31:0] nxt_fetch;
    int          outst;
    int          pops = 0;
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            chk("req_in_reset", {31'b0, imem_req}, 32'd0);
            exp_pc    = 32'h0;
            nxt_fetch = 32'h0;
            outst     = 0;
        end else begin
            if (inst_valid && inst_ready) begin
                chk("sb_pc", inst_pc, exp_pc);
                chk("sb_inst", inst, exp_pc ^ K);
                chk("sb_pc4", inst_pc4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                outst--;
                pops++;
            end
            if (redirect) begin
                chk("req_in_redirect", {31'b0, imem_req}, 32'd0);
                exp_pc    = redirect_pc & 32'hFFFF_FFFC;
                nxt_fetch = exp_pc;
                outst     = 0;
            end else if (imem_req && imem_gnt) begin
                chk("sb_addr", imem_addr, nxt_fetch);
                nxt_fetch = nxt_fetch + 32'd4;
                outst++;
                chk("sb_credit", {31'b0, outst <= DEPTH}, 32'd1);
            end
        end
    end

    typedef struct {
        logic        rst;
        logic        gnt;
        logic        rdy;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl [9];

    task automatic do_reset();
        reset      = 1'b0;
        redirect   = 1'b0;
        imem_gnt   = 1'b0;
        inst_ready = 1'b0;
        tick();
    endtask

    initial begin
        int acc;
        reset       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b0;
        inst_ready  = 1'b0;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 32'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd12, 1'b1, 32'd4};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd16, 1'b1, 32'd8};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd20, 1'b1, 32'd12};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'd24, 1'b1, 32'd16};

        tick();
        for (int i = 0; i < 9; i++) begin
            reset      = tbl[i].rst;
            imem_gnt   = tbl[i].gnt;
            inst_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("tbl%0d_req", i), {31'b0, imem_req},
                {31'b0, tbl[i].e_req});
            chk($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), {31'b0, inst_valid},
                {31'b0, tbl[i].e_valid});
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i), inst_pc, tbl[i].e_pc);
                chk($sformatf("tbl%0d_inst", i), inst, tbl[i].e_pc ^ K);
                chk($sformatf("tbl%0d_pc4", i), inst_pc4,
                    tbl[i].e_pc + 32'd4);
            end
            if (!tbl[i].rst) begin
                chk($sformatf("tbl%0d_rst_pc", i), inst_pc, 32'd0);
                chk($sformatf("tbl%0d_rst_inst", i), inst, 32'd0);
            end
            tick();
        end

        // Backpressure: exactly DEPTH accepts, then credit returns
        // the cycle after a pop.
        do_reset();
        reset    = 1'b1;
        imem_gnt = 1'b1;
        acc      = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) begin
                chk("bp_addr", imem_addr, 32'(acc * 4));
                acc++;
            end
            tick();
        end
        chk("bp_accepts", 32'(acc), 32'd4);
        inst_ready = 1'b1;
        @(negedge clk);
        chk("bp_req_low", {31'b0, imem_req}, 32'd0);
        chk("bp_valid", {31'b0, inst_valid}, 32'd1);
        chk("bp_head", inst_pc, 32'd0);
        tick();
        inst_ready = 1'b0;
        @(negedge clk);
        chk("bp_req_back", {31'b0, imem_req}, 32'd1);
        chk("bp_addr16", imem_addr, 32'd16);
        tick();

        // Grant stall at address 8.
        do_reset();
        reset      = 1'b1;
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        tick();
        tick();
        imem_gnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_addr", imem_addr, 32'd8);
            chk("stall_req", {31'b0, imem_req}, 32'd1);
            tick();
        end
        imem_gnt = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        chk("stall_stream_end", exp_pc, 32'd40);

        // Redirect right after the accept at address 20.
        do_reset();
        reset      = 1'b1;
        imem_gnt   = 1'b1;
        inst_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rd_pre_addr", imem_addr, 32'(c * 4));
            tick();
        end
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        @(negedge clk);
        chk("rd_req_low", {31'b0, imem_req}, 32'd0);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("rd_new_addr", imem_addr, 32'h100);
        chk("rd_new_req", {31'b0, imem_req}, 32'd1);
        chk("rd_flushed1", {31'b0, inst_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("rd_flushed2", {31'b0, inst_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("rd_first_valid", {31'b0, inst_valid}, 32'd1);
        chk("rd_first_pc", inst_pc, 32'h100);
        tick();
        for (int c = 0; c < 4; c++) tick();

        // Reset with three entries buffered and one response in flight.
        do_reset();
        reset    = 1'b1;
        imem_gnt = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        @(negedge clk);
        chk("mr_pre_valid", {31'b0, inst_valid}, 32'd1);
        chk("mr_pre_req", {31'b0, imem_req}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("mr_valid0", {31'b0, inst_valid}, 32'd0);
        chk("mr_req", {31'b0, imem_req}, 32'd1);
        chk("mr_addr", imem_addr, 32'd0);
        tick();
        @(negedge clk);
        chk("mr_valid1", {31'b0, inst_valid}, 32'd0);
        tick();
        @(negedge clk);
        chk("mr_restart_valid", {31'b0, inst_valid}, 32'd1);
        chk("mr_restart_pc", inst_pc, 32'd0);
        tick();

        // Randomized traffic, including PC wrap near the top of memory.
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(99) != 0);
            redirect    = ($urandom_range(19) == 0);
            redirect_pc = ($urandom_range(3) == 0) ?
                          (32'hFFFF_FFF0 | 32'($urandom_range(15))) :
                          $urandom;
            imem_gnt    = ($urandom_range(3) != 0);
            inst_ready  = 1'($urandom_range(1));
            tick();
        end
        chk("rand_progress", {31'b0, pops > 300}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
